// File: rtl/instr_enc_pkg.sv
// instr_enc_pkg: operation, opcode/funct and FSM state definitions shared by
// the instruction stream encoder and its combinational word encoder.
package instr_enc_pkg;

    typedef enum logic [3:0] {
        OP_ADD     = 4'd0,
        OP_SUB     = 4'd1,
        OP_AND     = 4'd2,
        OP_OR      = 4'd3,
        OP_SLT     = 4'd4,
        OP_SLL     = 4'd5,
        OP_SRL     = 4'd6,
        OP_MUL     = 4'd7,
        OP_CLO     = 4'd8,
        OP_CLZ     = 4'd9,
        OP_ADDI    = 4'd10,
        OP_ORI     = 4'd11,
        OP_BNE     = 4'd12,
        OP_LW      = 4'd13,
        OP_SW      = 4'd14,
        OP_INVALID = 4'd15
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Primary opcodes
    localparam logic [5:0] OPC_RTYPE    = 6'b000000;
    localparam logic [5:0] OPC_SPECIAL2 = 6'b011100;
    localparam logic [5:0] OPC_ADDI     = 6'b001000;
    localparam logic [5:0] OPC_ORI      = 6'b001101;
    localparam logic [5:0] OPC_BNE      = 6'b000101;
    localparam logic [5:0] OPC_LW       = 6'b100011;
    localparam logic [5:0] OPC_SW       = 6'b101011;

    // R-type funct codes
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;

    // SPECIAL2 funct codes
    localparam logic [5:0] FN_MUL = 6'b000010;
    localparam logic [5:0] FN_CLO = 6'b100001;
    localparam logic [5:0] FN_CLZ = 6'b100000;

    // Assemble an R-format word (also used for SPECIAL2).
    function automatic logic [31:0] pack_r(
        input logic [5:0] opc,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic [4:0] rd,
        input logic [4:0] sh,
        input logic [5:0] fn
    );
        return {opc, rs, rt, rd, sh, fn};
    endfunction

    // Assemble an I-format word.
    function automatic logic [31:0] pack_i(
        input logic [5:0]  opc,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [15:0] imm
    );
        return {opc, rs, rt, imm};
    endfunction

endpackage

// File: rtl/instr_word_encode.sv
// instr_word_encode: combinational Op/fields -> 32-bit MIPS word plus an
// invalid flag. MUL/CLO/CLZ are encoded only when ENC_SPECIAL2_EN is defined;
// otherwise they are reported invalid.
module instr_word_encode
    import instr_enc_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [15:0] imm,
    output logic [31:0] word,
    output logic        invalid
);

    // Select format and fixed fields for the requested operation.
    always_comb begin
        word    = '0;
        invalid = 1'b0;
        case (op_e'(op))
            OP_ADD:  word = pack_r(OPC_RTYPE, rs, rt, rd, 5'd0, FN_ADD);
            OP_SUB:  word = pack_r(OPC_RTYPE, rs, rt, rd, 5'd0, FN_SUB);
            OP_AND:  word = pack_r(OPC_RTYPE, rs, rt, rd, 5'd0, FN_AND);
            OP_OR:   word = pack_r(OPC_RTYPE, rs, rt, rd, 5'd0, FN_OR);
            OP_SLT:  word = pack_r(OPC_RTYPE, rs, rt, rd, 5'd0, FN_SLT);
            OP_SLL:  word = pack_r(OPC_RTYPE, 5'd0, rt, rd, shamt, FN_SLL);
            OP_SRL:  word = pack_r(OPC_RTYPE, 5'd0, rt, rd, shamt, FN_SRL);
`ifdef ENC_SPECIAL2_EN
            OP_MUL:  word = pack_r(OPC_SPECIAL2, rs, rt, rd, 5'd0, FN_MUL);
            // CLO/CLZ carry the destination in both the rt and rd fields.
            OP_CLO:  word = pack_r(OPC_SPECIAL2, rs, rd, rd, 5'd0, FN_CLO);
            OP_CLZ:  word = pack_r(OPC_SPECIAL2, rs, rd, rd, 5'd0, FN_CLZ);
`else
            OP_MUL, OP_CLO, OP_CLZ: invalid = 1'b1;
`endif
            OP_ADDI: word = pack_i(OPC_ADDI, rs, rt, imm);
            OP_ORI:  word = pack_i(OPC_ORI, rs, rt, imm);
            OP_BNE:  word = pack_i(OPC_BNE, rs, rt, imm);
            OP_LW:   word = pack_i(OPC_LW, rs, rt, imm);
            OP_SW:   word = pack_i(OPC_SW, rs, rt, imm);
            default: invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_stream_encoder.sv
// instr_stream_encoder: encodes a session of operations into MIPS words and
// streams them to instruction memory through a FIFO plus a registered write
// stage. Optional SPECIAL2 ops (MUL/CLO/CLZ) are enabled by ENC_SPECIAL2_EN.
module instr_stream_encoder
    import instr_enc_pkg::*;
#(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Start,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [3:0]        Op,
    input  logic [4:0]        Rs,
    input  logic [4:0]        Rt,
    input  logic [4:0]        Rd,
    input  logic [4:0]        Shamt,
    input  logic [15:0]       Imm,
    input  logic              Last,
    output logic              IM_WrEn,
    output logic [ADDR_W-1:0] IM_Addr,
    output logic [31:0]       IM_WrData,
    input  logic              IM_Ready,
    output logic              Busy,
    output logic              Done,
    output logic              Error,
    output logic [ADDR_W-2:0] Count
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    state_e               state_q, state_d;
    logic [31:0]          mem_q [FIFO_DEPTH];
    logic [31:0]          mem_d [FIFO_DEPTH];
    logic [PTR_W:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]       rd_ptr_q, rd_ptr_d;
    logic                 out_valid_q, out_valid_d;
    logic [31:0]          out_data_q, out_data_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [ADDR_W-2:0]    count_q, count_d;
    logic                 error_q, error_d;

    logic [31:0] enc_word;
    logic        enc_invalid;
    logic        fifo_empty;
    logic        fifo_full;
    logic        accept;
    logic        push;
    logic        pop;
    logic        write_done;
    logic        session_start;

    instr_word_encode u_encode (
        .op      (Op),
        .rs      (Rs),
        .rt      (Rt),
        .rd      (Rd),
        .shamt   (Shamt),
        .imm     (Imm),
        .word    (enc_word),
        .invalid (enc_invalid)
    );

    // FIFO status and handshake qualifiers.
    always_comb begin
        fifo_empty    = (wr_ptr_q == rd_ptr_q);
        fifo_full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
        In_Ready      = (state_q == ST_LOAD) && !fifo_full;
        accept        = In_Valid && In_Ready;
        push          = accept && !enc_invalid;
        write_done    = out_valid_q && IM_Ready;
        // Refill the write stage whenever it is empty or retiring this cycle.
        pop           = !fifo_empty && (!out_valid_q || IM_Ready);
        session_start = (state_q == ST_IDLE) && Start;
    end

    // Session FSM next-state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (Start) state_d = ST_LOAD;
            ST_LOAD:  if (accept && Last) state_d = ST_DRAIN;
            // Finish as soon as the last write retires so Done follows it directly.
            ST_DRAIN: if (fifo_empty && (!out_valid_q || write_done)) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FIFO, write stage, address/count and error bookkeeping.
    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        addr_d      = addr_q;
        count_d     = count_q;
        error_d     = error_q;

        if (session_start) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            out_valid_d = 1'b0;
            addr_d      = BASE;
            count_d     = '0;
            error_d     = 1'b0;
        end else begin
            if (write_done) begin
                out_valid_d = 1'b0;
                addr_d      = addr_q + ADDR_W'(4);
                count_d     = count_q + 1'b1;
            end
            if (pop) begin
                out_valid_d = 1'b1;
                out_data_d  = mem_q[rd_ptr_q[PTR_W-1:0]];
                rd_ptr_d    = rd_ptr_q + 1'b1;
            end
            if (push) begin
                mem_d[wr_ptr_q[PTR_W-1:0]] = enc_word;
                wr_ptr_d                   = wr_ptr_q + 1'b1;
            end
            if (accept && enc_invalid) begin
                error_d = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers; reset discards buffered and in-flight words.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            addr_q      <= BASE;
            count_q     <= '0;
            error_q     <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            addr_q      <= addr_d;
            count_q     <= count_d;
            error_q     <= error_d;
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge Clk) begin
        mem_q <= mem_d;
    end

    // Output mapping.
    always_comb begin
        IM_WrEn   = out_valid_q;
        IM_Addr   = addr_q;
        IM_WrData = out_data_q;
        Busy      = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
        Done      = (state_q == ST_DONE);
        Error     = error_q;
        Count     = count_q;
    end

endmodule

// File: tb/tb_instr_stream_encoder.sv
// tb_instr_stream_encoder: directed vectors with hand-computed MIPS words.
// A second instance with BASE_ADDR=0x3FC exercises address wrap.
module tb_instr_stream_encoder;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        Start = 1'b0;
    logic        In_Valid = 1'b0;
    logic [3:0]  Op = '0;
    logic [4:0]  Rs = '0, Rt = '0, Rd = '0, Shamt = '0;
    logic [15:0] Imm = '0;
    logic        Last = 1'b0;
    logic        IM_Ready = 1'b1;

    logic        In_Ready, IM_WrEn, Busy, Done, Error;
    logic [9:0]  IM_Addr;
    logic [31:0] IM_WrData;
    logic [8:0]  Count;

    logic        h_In_Ready, h_IM_WrEn, h_Busy, h_Done, h_Error;
    logic [9:0]  h_IM_Addr;
    logic [31:0] h_IM_WrData;
    logic [8:0]  h_Count;

    int n_vec = 0;
    int n_err = 0;

    logic [9:0]  wr_addr[$];
    logic [31:0] wr_data[$];
    logic [9:0]  h_wr_addr[$];

    always #5 Clk = ~Clk;

    instr_stream_encoder #(.ADDR_W(10), .FIFO_DEPTH(4), .BASE_ADDR(0)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .In_Valid(In_Valid), .In_Ready(In_Ready),
        .Op(Op), .Rs(Rs), .Rt(Rt), .Rd(Rd), .Shamt(Shamt), .Imm(Imm), .Last(Last),
        .IM_WrEn(IM_WrEn), .IM_Addr(IM_Addr), .IM_WrData(IM_WrData), .IM_Ready(IM_Ready),
        .Busy(Busy), .Done(Done), .Error(Error), .Count(Count)
    );

    instr_stream_encoder #(.ADDR_W(10), .FIFO_DEPTH(4), .BASE_ADDR('h3FC)) dut_hi (
        .Clk(Clk), .Rst(Rst), .Start(Start), .In_Valid(In_Valid), .In_Ready(h_In_Ready),
        .Op(Op), .Rs(Rs), .Rt(Rt), .Rd(Rd), .Shamt(Shamt), .Imm(Imm), .Last(Last),
        .IM_WrEn(h_IM_WrEn), .IM_Addr(h_IM_Addr), .IM_WrData(h_IM_WrData), .IM_Ready(IM_Ready),
        .Busy(h_Busy), .Done(h_Done), .Error(h_Error), .Count(h_Count)
    );

    // Memory-side model: record every completed write.
    always @(posedge Clk) begin
        if (!Rst && IM_WrEn && IM_Ready) begin
            wr_addr.push_back(IM_Addr);
            wr_data.push_back(IM_WrData);
        end
        if (!Rst && h_IM_WrEn && IM_Ready) begin
            h_wr_addr.push_back(h_IM_Addr);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic start_session();
        @(negedge Clk);
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
    endtask

    task automatic send_op(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                           input logic last);
        int waited;
        Op = op; Rs = rs; Rt = rt; Rd = rd; Shamt = sh; Imm = imm; Last = last;
        In_Valid = 1'b1;
        waited = 0;
        while (!In_Ready && waited < 40) begin
            @(negedge Clk);
            waited++;
        end
        if (!In_Ready) check("accept_timeout", 32'd0, 32'd1);
        @(negedge Clk);
        In_Valid = 1'b0;
        Last = 1'b0;
    endtask

    task automatic wait_done();
        int waited;
        waited = 0;
        while (!Done && waited < 60) begin
            @(negedge Clk);
            waited++;
        end
        if (!Done) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic clear_logs();
        wr_addr.delete();
        wr_data.delete();
        h_wr_addr.delete();
    endtask

    initial begin
        logic [31:0] exp_w [6];

        // Reset values
        repeat (3) @(negedge Clk);
        check("rst_in_ready", In_Ready, 0);
        check("rst_wren", IM_WrEn, 0);
        check("rst_addr", IM_Addr, 0);
        check("rst_wrdata", IM_WrData, 0);
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        check("rst_error", Error, 0);
        check("rst_count", Count, 0);
        check("rst_hi_addr", h_IM_Addr, 32'h3FC);
        Rst = 1'b0;

        // Single ADD
        IM_Ready = 1'b1;
        clear_logs();
        start_session();
        check("busy_load", Busy, 1);
        check("in_ready_load", In_Ready, 1);
        send_op(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 1'b1);
        wait_done();
        check("add_count", Count, 1);
        check("add_nwr", wr_data.size(), 1);
        if (wr_data.size() >= 1) begin
            check("add_data", wr_data[0], 32'h00221820);
            check("add_addr", wr_addr[0], 0);
        end
        @(negedge Clk);
        check("done_one_cycle", Done, 0);
        check("busy_idle", Busy, 0);

        // LW then SLL
        clear_logs();
        start_session();
        send_op(4'd13, 5'd9, 5'd8, 5'd0, 5'd0, 16'd4, 1'b0);
        send_op(4'd5, 5'd7, 5'd3, 5'd2, 5'd4, 16'd0, 1'b1);
        wait_done();
        check("lwsll_count", Count, 2);
        check("lwsll_nwr", wr_data.size(), 2);
        if (wr_data.size() >= 2) begin
            check("lw_data", wr_data[0], 32'h8D280004);
            check("lw_addr", wr_addr[0], 0);
            check("sll_data", wr_data[1], 32'h00031100);
            check("sll_addr", wr_addr[1], 4);
        end

        // MUL, dependent on the SPECIAL2 build option
        clear_logs();
        start_session();
        send_op(4'd7, 5'd5, 5'd6, 5'd4, 5'd0, 16'd0, 1'b1);
        wait_done();
`ifdef ENC_SPECIAL2_EN
        check("mul_nwr", wr_data.size(), 1);
        if (wr_data.size() >= 1) check("mul_data", wr_data[0], 32'h70A62002);
        check("mul_error", Error, 0);
`else
        check("mul_nwr", wr_data.size(), 0);
        check("mul_error", Error, 1);
        check("mul_count", Count, 0);
`endif

        // Invalid op 15 mid-session: skipped, Error sticky, Start clears it
        clear_logs();
        start_session();
        check("start_clears_error", Error, 0);
        send_op(4'd15, 5'd1, 5'd1, 5'd1, 5'd0, 16'd0, 1'b0);
        send_op(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 1'b1);
        wait_done();
        check("inv_error", Error, 1);
        check("inv_nwr", wr_data.size(), 1);
        if (wr_data.size() >= 1) begin
            check("inv_next_addr", wr_addr[0], 0);
            check("inv_next_data", wr_data[0], 32'h00221820);
        end

        // Backpressure: 5 accepted (4 buffered + 1 held), then stall
        clear_logs();
        IM_Ready = 1'b0;
        start_session();
        for (int i = 0; i < 5; i++) send_op(4'd10, 5'd0, 5'd1, 5'd0, 5'd0, 16'(i), 1'b0);
        check("bp_in_ready_low", In_Ready, 0);
        check("bp_wren", IM_WrEn, 1);
        check("bp_addr_hold", IM_Addr, 0);
        check("bp_data_hold", IM_WrData, 32'h20010000);
        repeat (5) @(negedge Clk);
        check("bp_in_ready_still_low", In_Ready, 0);
        check("bp_data_stable", IM_WrData, 32'h20010000);
        IM_Ready = 1'b1;
        send_op(4'd10, 5'd0, 5'd1, 5'd0, 5'd0, 16'd5, 1'b1);
        wait_done();
        check("bp_count", Count, 6);
        check("bp_nwr", wr_data.size(), 6);
        for (int i = 0; i < 6; i++) exp_w[i] = 32'h20010000 + 32'(i);
        for (int i = 0; i < 6; i++) begin
            if (i < wr_data.size()) begin
                check($sformatf("bp_data%0d", i), wr_data[i], exp_w[i]);
                check($sformatf("bp_addr%0d", i), wr_addr[i], 32'(4 * i));
            end
        end

        // Address wrap on the high-base instance
        clear_logs();
        start_session();
        send_op(4'd3, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 1'b0);
        send_op(4'd1, 5'd4, 5'd5, 5'd6, 5'd0, 16'd0, 1'b1);
        wait_done();
        check("wrap_done_hi", h_Done, 1);
        check("wrap_count_hi", h_Count, 2);
        check("wrap_nwr", h_wr_addr.size(), 2);
        if (h_wr_addr.size() >= 2) begin
            check("wrap_addr0", h_wr_addr[0], 32'h3FC);
            check("wrap_addr1", h_wr_addr[1], 32'h000);
        end

        // Reset mid-LOAD with words buffered
        clear_logs();
        IM_Ready = 1'b0;
        start_session();
        for (int i = 0; i < 4; i++) send_op(4'd11, 5'd2, 5'd3, 5'd0, 5'd0, 16'(i), 1'b0);
        check("pre_rst_wren", IM_WrEn, 1);
        Rst = 1'b1;
        @(negedge Clk);
        check("rst_mid_wren", IM_WrEn, 0);
        check("rst_mid_busy", Busy, 0);
        check("rst_mid_in_ready", In_Ready, 0);
        Rst = 1'b0;
        IM_Ready = 1'b1;
        start_session();
        send_op(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 1'b1);
        wait_done();
        check("post_rst_nwr", wr_data.size(), 1);
        if (wr_data.size() >= 1) begin
            check("post_rst_addr", wr_addr[0], 0);
            check("post_rst_data", wr_data[0], 32'h00221820);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
